// File: rtl/rgbw_spi_master.sv
// rgbw_spi_master: SPI mode-0 transmitter for RGBW lamp command frames.
// Accepts a valid/ready byte stream with an end-of-frame flag and drives a
// cs-framed, MSB-first serial stream. Every output is a register.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   tx_data    byte to send
//   tx_last    final byte of the frame (qualified by tx_valid)
//   tx_valid   tx_data/tx_last valid
//   tx_ready   byte accepted when tx_valid is also high
//   sck        SPI clock, idles low
//   cs         chip select, active low
//   mosi       serial data, MSB first
//   busy       state is not IDLE
//   frame_done one-cycle pulse coincident with cs rising at frame end
module rgbw_spi_master #(
   parameter int unsigned SCK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_GAP   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       sck,
   output logic       cs,
   output logic       mosi,
   output logic       busy,
   output logic       frame_done
);

   // One shared counter sized for the longest programmable interval.
   localparam int unsigned MAX_A   = (SCK_DIV > CS_SETUP) ? SCK_DIV : CS_SETUP;
   localparam int unsigned MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
   localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [6:0]       shift_q, shift_d;   // bits still to send after the one on mosi
   logic             last_q, last_d;
   logic             sck_q, sck_d;
   logic             cs_q, cs_d;
   logic             mosi_q, mosi_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             accept;

   assign accept = tx_valid & tx_ready_q;

   // State register and output flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         last_q       <= 1'b0;
         sck_q        <= 1'b0;
         cs_q         <= 1'b1;
         mosi_q       <= 1'b0;
         tx_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         last_q       <= last_d;
         sck_q        <= sck_d;
         cs_q         <= cs_d;
         mosi_q       <= mosi_d;
         tx_ready_q   <= tx_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      last_d       = last_q;
      sck_d        = sck_q;
      cs_d         = cs_q;
      mosi_d       = mosi_q;
      frame_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d = tx_data[6:0];
               mosi_d  = tx_data[7];
               last_d  = tx_last;
               cs_d    = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            // Enter SHIFT with sck already high: the first rise ends setup.
            if (cnt_q == SETUP_LAST) begin
               sck_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               if (sck_q) begin
                  // Falling edge: advance mosi, except after bit 0 which is held.
                  if (bit_q == 3'd7) begin
                     state_d = last_q ? S_HOLD : S_WAIT;
                  end else begin
                     mosi_d  = shift_q[6];
                     shift_d = {shift_q[5:0], 1'b0};
                     bit_d   = bit_q + 3'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            // Reload with sck low; the first rise comes one half-period later.
            if (accept) begin
               shift_d = tx_data[6:0];
               mosi_d  = tx_data[7];
               last_d  = tx_last;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cs_d         = 1'b1;
               frame_done_d = 1'b1;
               mosi_d       = 1'b0;
               cnt_d        = '0;
               state_d      = S_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered from the next state so they line up with it.
      tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
      busy_d     = (state_d != S_IDLE);
   end

   assign tx_ready   = tx_ready_q;
   assign sck        = sck_q;
   assign cs         = cs_q;
   assign mosi       = mosi_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
